// File: rtl/seq_match_search.sv
// Sequential search controller: scans a DEPTH-entry reference table with one
// shared equality compare per cycle and reports hit/miss plus the lowest matching index.
module seq_match_search #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [IDX_WIDTH-1:0]  wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  clr_i,
    input  logic                  search_valid_i,
    input  logic [DATA_WIDTH-1:0] search_key_i,
    output logic                  search_ready_o,
    output logic                  busy_o,
    output logic                  result_valid_o,
    output logic                  result_hit_o,
    output logic [IDX_WIDTH-1:0]  result_idx_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic [DATA_WIDTH-1:0] entry_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;

    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  hit_q, hit_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  rvalid_q, rvalid_d;

    logic [DATA_WIDTH-1:0] cmp_entry;
    logic                  cmp_valid;
    logic                  match;
    logic                  last;

    // Table update: clear first so a same-cycle write leaves its entry valid
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clr_i) begin
            valid_d = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_idx_i == IDX_WIDTH'(i))) begin
                entry_d[i] = wr_data_i;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Entry selection for the single shared comparator; indices >= DEPTH select nothing
    always_comb begin
        cmp_entry = '0;
        cmp_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ptr_q == IDX_WIDTH'(i)) begin
                cmp_entry = entry_q[i];
                cmp_valid = valid_q[i];
            end
        end
    end

    assign match = cmp_valid && (cmp_entry == key_q);
    assign last  = (ptr_q == IDX_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (search_valid_i) state_d = SCAN;
            SCAN:    if (match || last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered handshake/status outputs follow the upcoming state
    always_comb begin
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        rvalid_d = 1'b0;
        case (state_d)
            IDLE:    ready_d  = 1'b1;
            SCAN:    busy_d   = 1'b1;
            DONE:    rvalid_d = 1'b1;
            default: ready_d  = 1'b1;
        endcase
    end

    // Key latch, scan pointer and result registers
    always_comb begin
        key_d = key_q;
        ptr_d = ptr_q;
        hit_d = hit_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: begin
                if (search_valid_i) begin
                    key_d = search_key_i;
                    ptr_d = '0;
                end
            end
            SCAN: begin
                if (match) begin
                    hit_d = 1'b1;
                    idx_d = ptr_q;
                end else if (last) begin
                    hit_d = 1'b0;
                    idx_d = '0;
                end else begin
                    ptr_d = ptr_q + IDX_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q    <= '0;
            ptr_q    <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            ptr_q    <= ptr_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign search_ready_o = ready_q;
    assign busy_o         = busy_q;
    assign result_valid_o = rvalid_q;
    assign result_hit_o   = hit_q;
    assign result_idx_o   = idx_q;

endmodule

// File: tb/tb_seq_match_search.sv
// Bench for seq_match_search: directed test-plan steps plus randomized searches
// checked against a table model that predicts the first valid match per compare cycle.
module tb_seq_match_search;

    localparam int unsigned DW    = 13;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_key = '0;
    logic          s_ready;
    logic          busy;
    logic          r_valid;
    logic          r_hit;
    logic [IW-1:0] r_idx;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] ref_data  [DEPTH];
    logic          ref_valid [DEPTH];

    always #5 clk = ~clk;

    seq_match_search dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_idx_i       (wr_idx),
        .wr_data_i      (wr_data),
        .clr_i          (clr),
        .search_valid_i (s_valid),
        .search_key_i   (s_key),
        .search_ready_o (s_ready),
        .busy_o         (busy),
        .result_valid_o (r_valid),
        .result_hit_o   (r_hit),
        .result_idx_o   (r_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_data[i]  = '0;
            ref_valid[i] = 1'b0;
        end
    endtask

    // One clock: the model applies the inputs seen at the rising edge, then we park on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
            end
            if (wr_en && (int'(wr_idx) < DEPTH)) begin
                ref_data[int'(wr_idx)]  = wr_data;
                ref_valid[int'(wr_idx)] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic write(input int idx, input logic [DW-1:0] data, input logic with_clr);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = data;
        clr     = with_clr;
        tick();
        wr_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Full search; entry k is compared in the k-th cycle after accept, against the table as it
    // stands then. An optional write/clear event is driven in the cycle comparing entry ev_ptr.
    task automatic search(input string tag, input logic [DW-1:0] key, input int ev_ptr,
                          input logic ev_wr, input int ev_idx, input logic [DW-1:0] ev_data,
                          input logic ev_clr);
        logic exp_hit;
        int   exp_idx;
        exp_hit = 1'b0;
        exp_idx = 0;
        check({tag, "_ready_idle"}, 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_key   = key;
        tick();
        s_valid = 1'b0;
        s_key   = DW'($urandom);
        for (int k = 0; k < DEPTH; k++) begin
            check({tag, "_scan_rdy_busy_rv"}, 32'({s_ready, busy, r_valid}), 32'b010);
            if (ref_valid[k] && (ref_data[k] == key)) begin
                exp_hit = 1'b1;
                exp_idx = k;
            end
            if (k == ev_ptr) begin
                wr_en   = ev_wr;
                wr_idx  = IW'(ev_idx);
                wr_data = ev_data;
                clr     = ev_clr;
            end
            tick();
            wr_en = 1'b0;
            clr   = 1'b0;
            if (exp_hit) break;
        end
        check({tag, "_done_rdy_busy_rv"}, 32'({s_ready, busy, r_valid}), 32'b001);
        check({tag, "_hit"}, 32'(r_hit), 32'(exp_hit));
        check({tag, "_idx"}, 32'(r_idx), 32'(exp_idx));
        tick();
        check({tag, "_after_rdy_rv"}, 32'({s_ready, r_valid}), 32'b10);
    endtask

    initial begin
        logic [DW-1:0] pool [4];
        model_reset();

        // Reset asserted between edges takes effect immediately
        #2 rst = 1'b1;
        #1;
        check("reset_rdy_busy_rv", 32'({s_ready, busy, r_valid}), 32'b100);
        check("reset_hit_idx", 32'({r_hit, r_idx}), 32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        search("empty_miss", 13'h000, -1, 1'b0, 0, '0, 1'b0);

        // Hit and miss latency on an ascending table
        for (int i = 0; i < DEPTH; i++) write(i, DW'(13'h100 + i), 1'b0);
        search("hit3", 13'h103, -1, 1'b0, 0, '0, 1'b0);
        search("miss_all", 13'h1FFF, -1, 1'b0, 0, '0, 1'b0);

        // Duplicates: lowest index wins; clear with same-cycle write keeps the written entry
        do_clear();
        write(2, 13'h0AA, 1'b0);
        write(5, 13'h0AA, 1'b0);
        search("dup_low", 13'h0AA, -1, 1'b0, 0, '0, 1'b0);
        write(5, 13'h0AA, 1'b1);
        search("clr_wr_wins", 13'h0AA, -1, 1'b0, 0, '0, 1'b0);

        // Write ahead of the pointer during a scan
        do_clear();
        search("wr_midscan", 13'h155, 2, 1'b1, 6, 13'h155, 1'b0);

        // Clear during a scan drops an entry not yet compared
        do_clear();
        write(4, 13'h155, 1'b0);
        search("clr_midscan", 13'h155, 1, 1'b0, 0, '0, 1'b1);

        // Reset while the pointer sits at 3: no result strobe, table emptied
        do_clear();
        for (int i = 0; i < DEPTH; i++) write(i, DW'(13'h100 + i), 1'b0);
        s_valid = 1'b1;
        s_key   = 13'h103;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_rdy_busy_rv", 32'({s_ready, busy, r_valid}), 32'b100);
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_strobe", 32'({r_valid, busy}), 32'b00);
            tick();
        end
        search("midrst_miss", 13'h103, -1, 1'b0, 0, '0, 1'b0);

        // Randomized tables drawn from a small value pool so duplicates and hits are common
        for (int p = 0; p < 4; p++) pool[p] = DW'($urandom);
        for (int it = 0; it < 40; it++) begin
            int nw;
            if ($urandom_range(0, 4) == 0) do_clear();
            nw = int'($urandom_range(0, 4));
            for (int w = 0; w < nw; w++) begin
                write(int'($urandom_range(0, DEPTH - 1)), pool[$urandom_range(0, 3)],
                      ($urandom_range(0, 7) == 0));
            end
            search("rand", ($urandom_range(0, 5) == 0) ? DW'($urandom) : pool[$urandom_range(0, 3)],
                   ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DEPTH - 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                   pool[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
